multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control unit for the multicycle MIPS datapath; the next generation after the single-cycle opcode decoder.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, producing per-cycle datapath strobes.
- Adds a memory ready handshake, a latched opcode and a retired-instruction counter.
- Supports lw, sw, R-type, addi, beq, bne and j.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, aluop width; upper bits beyond [1:0] are driven 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwrite_eq / pcwrite_ne  out  1 each  conditional PC load for beq/bne.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread / memwrite  out  1 each  memory strobes.
- irwrite  out  1  IR load.
- memtoreg, regdst, regwrite  out  1 each  register file control.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- aluop  out  ALUOP_W  00 = add, 01 = sub, 10 = funct.
- pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding.
- retired  out  CNT_W  retired-instruction count.
- trap  out  1  illegal opcode flag; feature-dependent, see below.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=13.
- Reset: when rst_n=0 at a clk edge, state<=IDLE, op_q<=0, retired<=0. Reset mid-instruction aborts it without a retire count.
- All outputs are 0 in IDLE; any output not listed for a state is 0. IDLE->FETCH unconditionally.
- FETCH: memread=1, alusrcb=01, aluop=00, pcsrc=00. Stays in FETCH while mem_ready=0. When mem_ready=1: irwrite=1, pcwrite=1 (Mealy, same cycle), go to DECODE.
- DECODE: alusrcb=11, aluop=00; op_q<=opcode.
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) / 000101 (bne) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - other -> see Optional Feature
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state MEMRD if op_q is lw, else MEMWR.
- MEMRD: iord=1, memread=1. Waits on mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1. Waits on mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regdst=1, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. pcwrite_eq=1 if op_q is beq; pcwrite_ne=1 if op_q is bne. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Memory strobes (memread/memwrite) are held constant throughout a wait; mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Retired counter:
  - retired += 1 on every clock transition into FETCH from any state other than IDLE.
  - Wraps modulo 2^CNT_W.
  - Reset has priority over an increment in the same cycle.
- Latency in cycles with mem_ready tied to 1:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP.
  - TRAP asserts trap=1 with all other outputs 0, and holds until reset.
  - No retire count for the trapped instruction.
- Undefined:
  - Unknown opcode is treated as a nop: DECODE -> FETCH, and retired increments.
  - trap is tied to 0 and TRAP is unreachable.

Test Plan:
- Reset and start: rst_n=0 for 2 clk, then 1, mem_ready=1 -> state 0 then 1; all outputs 0 in IDLE; retired=0.
- lw with memory wait: opcode=100011, mem_ready low for 2 cycles in MEMRD -> sequence 1,2,3,4,4,4,5,1; memread=iord=1 held through the wait; regwrite=memtoreg=1 in MEMWB; retired=1.
- beq/bne: opcode=000100 -> BRANCH with pcwrite_eq=1, pcwrite_ne=0, aluop=01, pcsrc=01. Repeat with 000101 -> pcwrite_ne=1 only.
- Mixed stream R-type, addi, sw, j with mem_ready=1 -> per-state strobes exactly as specified; retired=4 after 15 cycles from the first FETCH.
- Illegal opcode 111111:
  - with MC_CTRL_ILLEGAL_TRAP_EN -> state 13, trap=1, retired unchanged, exits only on rst_n=0;
  - without -> returns to FETCH and retired increments.
- Counter wrap: CNT_W=4, 16 j instructions -> retired wraps 15 -> 0. rst_n=0 asserted in MEMRD -> state IDLE next cycle and retired=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Handshake and strobe bundle between the multicycle control unit and the datapath.
// master = control unit, slave = datapath / memory side.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pcwrite;
    logic                pcwrite_eq;
    logic                pcwrite_ne;
    logic                iord;
    logic                memread;
    logic                memwrite;
    logic                irwrite;
    logic                memtoreg;
    logic                regdst;
    logic                regwrite;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [ALUOP_W-1:0]  aluop;
    logic [1:0]          pcsrc;
    logic [3:0]          state;
    logic [CNT_W-1:0]    retired;
    logic                trap;

    modport master (
        input  opcode, mem_ready,
        output pcwrite, pcwrite_eq, pcwrite_ne, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
               state, retired, trap
    );

    modport slave (
        output opcode, mem_ready,
        input  pcwrite, pcwrite_eq, pcwrite_ne, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
               state, retired, trap
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready handshake and retired-instruction counter.
// Define MC_CTRL_ILLEGAL_TRAP_EN to park unknown opcodes in a TRAP state instead of treating them as nops.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwrite_eq;
        logic       pcwrite_ne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    retired_q;
    ctrl_t               ctrl_q;
    logic                retire;
    logic                fetchAck;

    // Moore strobes for a state; registered against the next state so they line up with state_q.
    function automatic ctrl_t ctrlFor(input state_e s, input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:  begin c.iord = 1'b1; c.memread = 1'b1; end
            S_MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.aluop      = 2'b01;
                c.pcsrc      = 2'b01;
                c.pcwrite_eq = (op == OP_BEQ);
                c.pcwrite_ne = (op == OP_BNE);
            end
            S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:        state_d = S_TRAP;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Stalling in FETCH and leaving IDLE are not retirements.
    assign retire = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrlFor(state_d, op_d);
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    // IR and PC load on the cycle memory hands over the instruction word.
    assign fetchAck = (state_q == S_FETCH) && bus.mem_ready;

    assign bus.pcwrite    = ctrl_q.pcwrite | fetchAck;
    assign bus.irwrite    = fetchAck;
    assign bus.pcwrite_eq = ctrl_q.pcwrite_eq;
    assign bus.pcwrite_ne = ctrl_q.pcwrite_ne;
    assign bus.iord       = ctrl_q.iord;
    assign bus.memread    = ctrl_q.memread;
    assign bus.memwrite   = ctrl_q.memwrite;
    assign bus.memtoreg   = ctrl_q.memtoreg;
    assign bus.regdst     = ctrl_q.regdst;
    assign bus.regwrite   = ctrl_q.regwrite;
    assign bus.alusrca    = ctrl_q.alusrca;
    assign bus.alusrcb    = ctrl_q.alusrcb;
    assign bus.aluop      = ALUOP_W'(ctrl_q.aluop);
    assign bus.pcsrc      = ctrl_q.pcsrc;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.trap       = (state_q == S_TRAP);
`else
    assign bus.trap       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// against hand-written strobe vectors, plus counter wrap and mid-instruction reset.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] expRet;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(4)) bus ();

    multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Strobe vector layout: {pcwrite,eq,ne,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsrc,trap}
    localparam logic [17:0] B_PCW   = 18'd1 << 17;
    localparam logic [17:0] B_EQ    = 18'd1 << 16;
    localparam logic [17:0] B_NE    = 18'd1 << 15;
    localparam logic [17:0] B_IORD  = 18'd1 << 14;
    localparam logic [17:0] B_MR    = 18'd1 << 13;
    localparam logic [17:0] B_MW    = 18'd1 << 12;
    localparam logic [17:0] B_IRW   = 18'd1 << 11;
    localparam logic [17:0] B_M2R   = 18'd1 << 10;
    localparam logic [17:0] B_RD    = 18'd1 << 9;
    localparam logic [17:0] B_RW    = 18'd1 << 8;
    localparam logic [17:0] B_ASA   = 18'd1 << 7;
    localparam logic [17:0] ASB_4   = 18'd1 << 5;
    localparam logic [17:0] ASB_IMM = 18'd2 << 5;
    localparam logic [17:0] ASB_SH  = 18'd3 << 5;
    localparam logic [17:0] AOP_SUB = 18'd1 << 3;
    localparam logic [17:0] AOP_FN  = 18'd2 << 3;
    localparam logic [17:0] PS_OUT  = 18'd1 << 1;
    localparam logic [17:0] PS_J    = 18'd2 << 1;
    localparam logic [17:0] B_TRAP  = 18'd1;

    localparam logic [17:0] E_IDLE   = 18'd0;
    localparam logic [17:0] E_FWAIT  = B_MR | ASB_4;
    localparam logic [17:0] E_FACK   = B_MR | ASB_4 | B_IRW | B_PCW;
    localparam logic [17:0] E_DEC    = ASB_SH;
    localparam logic [17:0] E_MADR   = B_ASA | ASB_IMM;
    localparam logic [17:0] E_MRD    = B_IORD | B_MR;
    localparam logic [17:0] E_MWB    = B_M2R | B_RW;
    localparam logic [17:0] E_MWR    = B_IORD | B_MW;
    localparam logic [17:0] E_EXEC   = B_ASA | AOP_FN;
    localparam logic [17:0] E_ALUWB  = B_RD | B_RW;
    localparam logic [17:0] E_BEQ    = B_ASA | AOP_SUB | PS_OUT | B_EQ;
    localparam logic [17:0] E_BNE    = B_ASA | AOP_SUB | PS_OUT | B_NE;
    localparam logic [17:0] E_ADDIEX = B_ASA | ASB_IMM;
    localparam logic [17:0] E_ADDIWB = B_RW;
    localparam logic [17:0] E_JUMP   = PS_J | B_PCW;
    localparam logic [17:0] E_TRAP   = B_TRAP;

    wire [17:0] obsCtl = {bus.pcwrite, bus.pcwrite_eq, bus.pcwrite_ne, bus.iord, bus.memread,
                          bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite,
                          bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.trap};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic ready);
        bus.opcode    = op;
        bus.mem_ready = ready;
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] st, input logic [17:0] ctl);
        checkVal({tag, ".state"}, 32'(bus.state), 32'(st));
        checkVal({tag, ".ctl"}, 32'(obsCtl), 32'(ctl));
    endtask

    task automatic checkRetired(input string tag, input logic [3:0] exp);
        checkVal({tag, ".retired"}, 32'(bus.retired), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(6'b000000, 1'b1);
        tick();
        tick();
        checkOutput("reset", 4'd0, E_IDLE);
        checkRetired("reset", 4'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("start", 4'd1, E_FACK);

        // lw with two wait cycles in MEMRD; opcode bus changes mid-flight to prove op_q is used
        applyStimulus(6'b100011, 1'b1);
        checkOutput("lw.fetch", 4'd1, E_FACK);
        tick(); checkOutput("lw.decode", 4'd2, E_DEC);
        tick(); checkOutput("lw.memadr", 4'd3, E_MADR);
        applyStimulus(6'b101011, 1'b0);
        tick(); checkOutput("lw.memrd0", 4'd4, E_MRD);
        tick(); checkOutput("lw.memrd1", 4'd4, E_MRD);
        applyStimulus(6'b101011, 1'b1);
        checkOutput("lw.memrd2", 4'd4, E_MRD);
        tick(); checkOutput("lw.memwb", 4'd5, E_MWB);
        tick(); checkOutput("lw.done", 4'd1, E_FACK);
        checkRetired("lw", 4'd1);

        applyStimulus(6'b000100, 1'b1);
        tick(); checkOutput("beq.decode", 4'd2, E_DEC);
        tick(); checkOutput("beq.branch", 4'd9, E_BEQ);
        tick(); checkRetired("beq", 4'd2);

        applyStimulus(6'b000101, 1'b1);
        tick(); checkOutput("bne.decode", 4'd2, E_DEC);
        tick(); checkOutput("bne.branch", 4'd9, E_BNE);
        tick(); checkRetired("bne", 4'd3);

        // Fetch stall: strobes stay up, no IR/PC load, no retire
        applyStimulus(6'b000000, 1'b0);
        checkOutput("fetch.wait0", 4'd1, E_FWAIT);
        tick(); checkOutput("fetch.wait1", 4'd1, E_FWAIT);
        checkRetired("fetch.wait", 4'd3);
        applyStimulus(6'b000000, 1'b1);
        checkOutput("rtype.fetch", 4'd1, E_FACK);
        tick(); checkOutput("rtype.decode", 4'd2, E_DEC);
        tick(); checkOutput("rtype.exec", 4'd7, E_EXEC);
        tick(); checkOutput("rtype.aluwb", 4'd8, E_ALUWB);
        tick(); checkRetired("rtype", 4'd4);

        applyStimulus(6'b001000, 1'b1);
        tick(); checkOutput("addi.decode", 4'd2, E_DEC);
        tick(); checkOutput("addi.ex", 4'd10, E_ADDIEX);
        tick(); checkOutput("addi.wb", 4'd11, E_ADDIWB);
        tick(); checkRetired("addi", 4'd5);

        applyStimulus(6'b101011, 1'b1);
        tick(); checkOutput("sw.decode", 4'd2, E_DEC);
        tick(); checkOutput("sw.memadr", 4'd3, E_MADR);
        applyStimulus(6'b100011, 1'b0);
        tick(); checkOutput("sw.memwr0", 4'd6, E_MWR);
        applyStimulus(6'b100011, 1'b1);
        checkOutput("sw.memwr1", 4'd6, E_MWR);
        tick(); checkRetired("sw", 4'd6);

        applyStimulus(6'b000010, 1'b1);
        tick(); checkOutput("j.decode", 4'd2, E_DEC);
        tick(); checkOutput("j.jump", 4'd12, E_JUMP);
        tick(); checkOutput("j.done", 4'd1, E_FACK);
        checkRetired("j", 4'd7);

        applyStimulus(6'b111111, 1'b1);
        tick(); checkOutput("ill.decode", 4'd2, E_DEC);
        tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        checkOutput("ill.trap0", 4'd13, E_TRAP);
        tick(); tick();
        checkOutput("ill.trap2", 4'd13, E_TRAP);
        checkRetired("ill.trap", 4'd7);
`else
        checkOutput("ill.nop", 4'd1, E_FACK);
        checkRetired("ill.nop", 4'd8);
`endif

        // Counter wrap with a 4-bit counter over 16 jumps
        rst_n = 1'b0;
        tick();
        checkOutput("wrap.reset", 4'd0, E_IDLE);
        checkRetired("wrap.reset", 4'd0);
        rst_n = 1'b1;
        applyStimulus(6'b000010, 1'b1);
        tick();
        expRet = 4'd0;
        for (int i = 0; i < 16; i++) begin
            tick(); tick(); tick();
            expRet = expRet + 4'd1;
            checkRetired($sformatf("wrap.j%0d", i), expRet);
        end

        // Reset while waiting in MEMRD aborts without a retire
        tick(); tick(); tick();
        checkRetired("abort.pre", 4'd1);
        applyStimulus(6'b100011, 1'b1);
        tick(); tick();
        applyStimulus(6'b100011, 1'b0);
        tick(); checkOutput("abort.memrd", 4'd4, E_MRD);
        rst_n = 1'b0;
        tick(); checkOutput("abort.idle", 4'd0, E_IDLE);
        checkRetired("abort.idle", 4'd0);
        rst_n = 1'b1;
        applyStimulus(6'b000000, 1'b1);
        tick(); checkOutput("abort.fetch", 4'd1, E_FACK);
        checkRetired("abort.fetch", 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
